// File: rtl/rcc_pkg.sv
// Shared definitions for the ripple-counter sampler: FSM encoding and the
// default counter width shared with the ripple counter itself.
package rcc_pkg;

   localparam int unsigned DEFAULT_WIDTH = 16;

   typedef logic [1:0] state_t;

   localparam state_t IDLE   = 2'd0;
   localparam state_t SAMPLE = 2'd1;
   localparam state_t VALID  = 2'd2;

endpackage

// File: rtl/rcc_sampler_if.sv
// Request/result bundle between a requester and rcc_sampler. The master drives
// the raw count, the request and the ready; the sampler answers with the snapshot.
interface rcc_sampler_if
   import rcc_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
);

   logic [WIDTH-1:0] cnt_in;
   logic             req;
   logic             busy;
   logic [WIDTH-1:0] snap;
   logic [WIDTH-1:0] delta;
   logic             err;
   logic             snap_valid;
   logic             snap_ready;

   modport master (
      output cnt_in, req, snap_ready,
      input  busy, snap, delta, err, snap_valid
   );

   modport slave (
      input  cnt_in, req, snap_ready,
      output busy, snap, delta, err, snap_valid
   );

endinterface

// File: rtl/rcc_in_pipe.sv
// Free-running two-stage capture of the asynchronous ripple count; the two
// stages are compared downstream to reject values caught mid-ripple.
module rcc_in_pipe
   import rcc_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] cnt_in,
   output logic [WIDTH-1:0] cnt_q,
   output logic [WIDTH-1:0] cnt_qq
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q  <= '0;
         cnt_qq <= '0;
      end else begin
         cnt_q  <= cnt_in;
         cnt_qq <= cnt_q;
      end
   end

endmodule

// File: rtl/rcc_sampler.sv
// Captures a settled ripple-counter value on request, reports it with the
// modular delta to the previous good capture, or flags err if it never settles.
module rcc_sampler
   import rcc_pkg::*;
#(
   parameter int unsigned WIDTH     = DEFAULT_WIDTH,
   parameter int unsigned MAX_TRIES = 4
) (
   input logic          clk,
   input logic          reset,
   rcc_sampler_if.slave bus
);

   localparam int unsigned TRIES_W = $clog2(MAX_TRIES + 1);
   localparam logic [TRIES_W-1:0] LAST_TRY = TRIES_W'(MAX_TRIES - 1);

   logic [WIDTH-1:0]   cnt_q, cnt_qq;
   state_t             state_q, state_d;
   logic [TRIES_W-1:0] tries_q, tries_d;
   logic [WIDTH-1:0]   snap_q, snap_d;
   logic [WIDTH-1:0]   delta_q, delta_d;
   logic [WIDTH-1:0]   prev_q, prev_d;
   logic               err_q, err_d;
   logic               stable;
   logic               last_try;

   rcc_in_pipe #(
      .WIDTH (WIDTH)
   ) u_in_pipe (
      .clk    (clk),
      .reset  (reset),
      .cnt_in (bus.cnt_in),
      .cnt_q  (cnt_q),
      .cnt_qq (cnt_qq)
   );

   // Two consecutive samples agreeing means the ripple had settled.
   assign stable   = (cnt_q == cnt_qq);
   assign last_try = (tries_q == LAST_TRY);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.req) state_d = SAMPLE;
         SAMPLE:  if (stable || last_try) state_d = VALID;
         VALID:   if (bus.snap_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.busy       = (state_q != IDLE);
      bus.snap_valid = (state_q == VALID);
   end

   always_comb begin
      tries_d = tries_q;
      snap_d  = snap_q;
      delta_d = delta_q;
      prev_d  = prev_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (bus.req) tries_d = '0;
         end
         SAMPLE: begin
            if (stable) begin
               snap_d  = cnt_q;
               delta_d = cnt_q - prev_q;
               prev_d  = cnt_q;
               err_d   = 1'b0;
            end else if (last_try) begin
               err_d = 1'b1;
            end else begin
               tries_d = tries_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tries_q <= '0;
         snap_q  <= '0;
         delta_q <= '0;
         prev_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         tries_q <= tries_d;
         snap_q  <= snap_d;
         delta_q <= delta_d;
         prev_q  <= prev_d;
         err_q   <= err_d;
      end
   end

   assign bus.snap  = snap_q;
   assign bus.delta = delta_q;
   assign bus.err   = err_q;

endmodule

// File: tb/tb_rcc_sampler.sv
// Randomized scoreboard bench for rcc_sampler: expected results come from a
// per-capture input-sequence model and are checked by an independent monitor.
module tb_rcc_sampler;
   import rcc_pkg::*;

   localparam int unsigned W         = DEFAULT_WIDTH;
   localparam int unsigned MAX_TRIES = 4;
   localparam int unsigned SEQ_N     = MAX_TRIES + 3;

   typedef logic [W-1:0] seq_t [SEQ_N];
   typedef struct packed {
      logic [W-1:0] snap;
      logic [W-1:0] delta;
      logic         err;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   rcc_sampler_if #(.WIDTH(W)) bus ();

   rcc_sampler #(
      .WIDTH     (W),
      .MAX_TRIES (MAX_TRIES)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int   total = 0;
   int   bad   = 0;
   int   ready_mode = 0;
   exp_t exp_q[$];
   exp_t mon_e;
   logic [W-1:0] m_prev  = '0;
   logic [W-1:0] m_snap  = '0;
   logic [W-1:0] m_delta = '0;
   seq_t s;

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit hit, expected summary before it");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, want);
      end
   endtask

   // 0: random ready, 1: held low, 2: held high
   initial begin
      bus.snap_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         case (ready_mode)
            0:       bus.snap_ready = 1'($urandom_range(0, 1));
            1:       bus.snap_ready = 1'b0;
            default: bus.snap_ready = 1'b1;
         endcase
      end
   end

   always @(negedge clk) begin
      if (reset && bus.snap_valid) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: snap=%0h presented, expected no result", bus.snap);
         end else begin
            mon_e = exp_q[0];
            check("snap", 32'(bus.snap), 32'(mon_e.snap));
            check("delta", 32'(bus.delta), 32'(mon_e.delta));
            check("err", 32'(bus.err), 32'(mon_e.err));
            if (bus.snap_ready) void'(exp_q.pop_front());
         end
      end
   end

   // s[i] is the count seen at edge k-1+i, where edge k samples req. The first
   // adjacent equal pair within MAX_TRIES compares is the captured value.
   function automatic void model_capture(input seq_t sq, output exp_t e, output int lat);
      bit found;
      found = 1'b0;
      lat     = MAX_TRIES;
      e.err   = 1'b1;
      e.snap  = m_snap;
      e.delta = m_delta;
      for (int j = 1; j <= MAX_TRIES; j++) begin
         if (!found && sq[j] == sq[j-1]) begin
            found   = 1'b1;
            lat     = j;
            e.err   = 1'b0;
            e.snap  = sq[j];
            e.delta = sq[j] - m_prev;
            m_prev  = sq[j];
         end
      end
      m_snap  = e.snap;
      m_delta = e.delta;
   endfunction

   function automatic void make_seq(input logic [W-1:0] v, input int u, output seq_t sq);
      sq[0] = v;
      for (int i = 1; i < SEQ_N; i++) begin
         if (i <= u) sq[i] = sq[i-1] ^ W'($urandom_range(1, (2 ** W) - 1));
         else        sq[i] = sq[i-1];
      end
   endfunction

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 500 && !ok; i++) begin
         @(negedge clk);
         if (!bus.busy) ok = 1'b1;
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL idle_timeout: busy stuck at 1, expected 0 within 500 cycles");
      end
   endtask

   task automatic issue(input seq_t sq);
      exp_t e;
      int   lat;
      bit   seen;
      wait_idle();
      bus.cnt_in = sq[0];
      bus.req    = 1'b0;
      @(negedge clk);
      bus.cnt_in = sq[1];
      bus.req    = 1'b1;
      model_capture(sq, e, lat);
      exp_q.push_back(e);
      @(negedge clk);
      bus.req    = 1'b0;
      bus.cnt_in = sq[2];
      check("busy_after_req", 32'(bus.busy), 32'd1);
      check("valid_before_capture", 32'(bus.snap_valid), 32'd0);
      seen = 1'b0;
      for (int m = 2; m < SEQ_N && !seen; m++) begin
         @(negedge clk);
         if (bus.snap_valid) begin
            seen = 1'b1;
            check("latency", 32'(m - 1), 32'(lat));
         end else if (m + 1 < SEQ_N) begin
            bus.cnt_in = sq[m+1];
         end
      end
      if (!seen) begin
         total++;
         bad++;
         $display("FAIL valid_timeout: snap_valid stayed 0, expected 1 after %0d edges", lat);
      end
   endtask

   initial begin
      bus.cnt_in = '0;
      bus.req    = 1'b0;
      #3;
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_valid", 32'(bus.snap_valid), 32'd0);
      check("rst_snap", 32'(bus.snap), 32'd0);
      check("rst_delta", 32'(bus.delta), 32'd0);
      check("rst_err", 32'(bus.err), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      make_seq(16'h1234, 0, s); issue(s);
      make_seq(16'h1240, 0, s); issue(s);
      make_seq(16'hFFF0, 0, s); issue(s);
      make_seq(16'h0010, 0, s); issue(s);
      make_seq(W'($urandom), SEQ_N, s); issue(s);
      make_seq(16'h5A5A, 0, s); issue(s);
      make_seq(16'h5A70, 1, s); issue(s);

      // Results must hold and requests must be dropped under backpressure.
      wait_idle();
      ready_mode = 1;
      make_seq(16'hBEEF, 0, s); issue(s);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.req = (i % 2 == 0);
         check("bp_busy", 32'(bus.busy), 32'd1);
         check("bp_valid", 32'(bus.snap_valid), 32'd1);
      end
      @(negedge clk);
      bus.req    = 1'b0;
      ready_mode = 2;
      @(negedge clk);
      @(negedge clk);
      check("hs_busy", 32'(bus.busy), 32'd0);
      check("hs_valid", 32'(bus.snap_valid), 32'd0);
      @(negedge clk);
      check("no_queued_req", 32'(bus.busy), 32'd0);
      ready_mode = 0;

      // Asynchronous reset in the middle of an unstable capture.
      wait_idle();
      bus.cnt_in = ~bus.cnt_in;
      bus.req    = 1'b1;
      @(negedge clk);
      bus.req    = 1'b0;
      bus.cnt_in = ~bus.cnt_in;
      check("pre_rst_busy", 32'(bus.busy), 32'd1);
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("async_busy", 32'(bus.busy), 32'd0);
      check("async_valid", 32'(bus.snap_valid), 32'd0);
      check("async_snap", 32'(bus.snap), 32'd0);
      check("async_delta", 32'(bus.delta), 32'd0);
      check("async_err", 32'(bus.err), 32'd0);
      repeat (2) @(negedge clk);
      check("held_rst_busy", 32'(bus.busy), 32'd0);
      check("held_rst_snap", 32'(bus.snap), 32'd0);
      reset = 1'b1;
      exp_q.delete();
      m_prev  = '0;
      m_snap  = '0;
      m_delta = '0;
      make_seq(W'($urandom), 0, s); issue(s);

      for (int n = 0; n < 40; n++) begin
         make_seq(W'($urandom), $urandom_range(0, MAX_TRIES + 1), s);
         issue(s);
      end

      ready_mode = 2;
      wait_idle();
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rcc_sampler.md
Name: rcc_sampler

Overview:
- Consumer stage for the 16-bit ripple counter. It captures the counter's asynchronously settling output into the clk domain.
- The ripple counter runs off a slow, unrelated event clock, so its bits settle at different times.
- This block double-samples the count and accepts a value only when two consecutive samples agree.
- It presents the snapshot, plus the modular delta since the last good snapshot, over a valid/ready handshake.

Parameters:
- WIDTH, 16, counter width; matches the ripple counter output.
- MAX_TRIES, 4, number of unequal compares tolerated before aborting a capture with err.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- cnt_in  input  WIDTH  ripple counter output; asynchronous to clk.
- req  input  1  capture request; sampled only in IDLE.
- busy  output  1  high in any state other than IDLE.
- snap  output  WIDTH  last accepted count value.
- delta  output  WIDTH  snap minus previous accepted snap, modulo 2^WIDTH.
- err  output  1  capture aborted; no stable value within MAX_TRIES compares.
- snap_valid  output  1  snap/delta/err are presentable.
- snap_ready  input  1  consumer accepts the result.

Behaviour:
- Reset (reset=0, async): state=IDLE; cnt_q, cnt_qq, snap, delta, prev=0; err=0; snap_valid=0; busy=0; tries=0.
- Input pipeline: cnt_q<=cnt_in and cnt_qq<=cnt_q on every edge, in all states (free-running).
- States are IDLE, SAMPLE, VALID.
- IDLE:
  - req=1 at an edge -> SAMPLE, tries<=0.
  - req=0 -> stay in IDLE.
- SAMPLE, evaluated each edge:
  - If cnt_q==cnt_qq: snap<=cnt_q; delta<=cnt_q-prev (WIDTH-bit wrap); prev<=cnt_q; err<=0; snap_valid<=1; -> VALID.
  - Otherwise, if tries==MAX_TRIES-1: err<=1; snap_valid<=1; snap, delta and prev unchanged; -> VALID.
  - Otherwise: tries<=tries+1 and stay in SAMPLE.
- Latency: with cnt_in stable for at least 2 cycles before req, snap_valid rises on the 2nd edge counting the edge that samples req (edge k samples req, edge k+1 captures).
- VALID:
  - Outputs are held stable while snap_ready=0.
  - snap_valid & snap_ready at an edge -> snap_valid<=0, -> IDLE.
  - err holds its value until the next capture completes.
- req is ignored outside IDLE. No queuing; the requester must re-assert.
- req held high continuously: a new capture starts on the edge after the return to IDLE, so there is one IDLE cycle between captures.
- tries width is clog2(MAX_TRIES+1). MAX_TRIES=1 means a single compare.
- Delta wrap example: prev=16'hFFF0, new=16'h0010 -> delta=16'h0020.
- The first successful capture after reset gives delta=snap, because prev=0.
- A reset asserted mid-SAMPLE or mid-VALID aborts immediately to the reset values; there is no partial output.

Decomposition:
- Shared package rcc_pkg holds:
  - the state encoding localparams (IDLE=2'd0, SAMPLE=2'd1, VALID=2'd2);
  - the default WIDTH=16, shared with the ripple counter.
- One sub-module, rcc_in_pipe: a WIDTH-bit two-stage register (cnt_q, cnt_qq) with async active-low reset.
- The FSM, tries counter and delta subtractor stay in rcc_sampler.

Test Plan:
- Stable capture: cnt_in=16'h1234 held, one-cycle req pulse -> snap_valid rises 2 edges later; snap=16'h1234, delta=16'h1234, err=0, busy=1 until the handshake.
- Second capture: cnt_in changed to 16'h1240 and held, req -> snap=16'h1240, delta=16'h000C.
- Wrap-around: prev set via capture of 16'hFFF0, then capture of 16'h0010 -> delta=16'h0020.
- Unstable input: cnt_in toggles every clk, MAX_TRIES=4, req -> snap_valid after 4 compares with err=1; snap and delta keep their previous values; the next stable capture clears err.
- Backpressure and ignored req: snap_ready=0 for 5 cycles with req pulsing -> snap, delta and snap_valid constant, no new capture. Then snap_ready=1 -> IDLE one edge later, busy=0.
- Reset mid-SAMPLE: reset=0 asynchronously while unstable input is being sampled -> all outputs 0 at once, independent of clk. After release, IDLE and a normal capture works.
